// File: rtl/board_eval.sv
// Material evaluator: walks N 64-square boards in SDRAM, writes one signed score per board
// and tracks the best (max) score and its board index for the CPU.
module board_eval #(
    parameter int VAL_P = 100,
    parameter int VAL_N = 320,
    parameter int VAL_B = 330,
    parameter int VAL_R = 500,
    parameter int VAL_Q = 900,
    parameter int VAL_K = 20000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        slave_waitrequest,
    input  logic [3:0]  slave_address,
    input  logic        slave_read,
    output logic [31:0] slave_readdata,
    input  logic        slave_write,
    input  logic [31:0] slave_writedata,
    input  logic        master_waitrequest,
    output logic [31:0] master_address,
    output logic        master_read,
    input  logic [31:0] master_readdata,
    input  logic        master_readdatavalid,
    output logic        master_write,
    output logic [31:0] master_writedata
);
    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_ACK, S_CHECK, S_RD_SQ, S_ACC, S_WR_SCORE, S_NEXT, S_DONE
    } state_t;

    state_t      state_q;
    logic [31:0] src_base_q;
    logic [31:0] dst_base_q;
    logic [31:0] acc_q;
    logic [31:0] best_score_q;
    logic [7:0]  num_boards_q;
    logic [7:0]  best_idx_q;
    logic [7:0]  board_q;
    logic [7:0]  code_q;
    logic [5:0]  sq_q;
    logic        err_q;

    logic [7:0]  mag;
    logic [31:0] val;
    logic        bad_code;
    logic [31:0] acc_d;

    // -128 negates to 128, so it lands in the invalid-code branch like any |code| > 6.
    always_comb begin
        mag      = code_q[7] ? (~code_q + 8'd1) : code_q;
        val      = 32'd0;
        bad_code = 1'b0;
        case (mag)
            8'd0:    val = 32'd0;
            8'd1:    val = 32'(VAL_P);
            8'd2:    val = 32'(VAL_N);
            8'd3:    val = 32'(VAL_B);
            8'd4:    val = 32'(VAL_R);
            8'd5:    val = 32'(VAL_Q);
            8'd6:    val = 32'(VAL_K);
            default: bad_code = 1'b1;
        endcase
        acc_d = code_q[7] ? (acc_q - val) : (acc_q + val);
    end

    assign slave_waitrequest = !(state_q == S_IDLE || state_q == S_ACK || state_q == S_DONE);
    assign master_read       = (state_q == S_RD_SQ);
    assign master_write      = (state_q == S_WR_SCORE);
    assign master_writedata  = master_write ? acc_q : 32'hFFFF_FFFF;

    always_comb begin
        master_address = 32'hFFFF_FFFF;
        if (state_q == S_RD_SQ)
            master_address = src_base_q + {18'd0, board_q, sq_q};
        else if (state_q == S_WR_SCORE)
            master_address = dst_base_q + {24'd0, board_q};
    end

    always_comb begin
        slave_readdata = 32'd0;
        if (!slave_waitrequest) begin
            case (slave_address)
                4'd0:    slave_readdata = {30'd0, err_q, state_q == S_DONE};
                4'd1:    slave_readdata = src_base_q;
                4'd2:    slave_readdata = dst_base_q;
                4'd3:    slave_readdata = {24'd0, num_boards_q};
                4'd4:    slave_readdata = best_score_q;
                4'd5:    slave_readdata = {24'd0, best_idx_q};
                default: slave_readdata = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            src_base_q   <= 32'hFFFF_FFFF;
            dst_base_q   <= 32'hFFFF_FFFF;
            num_boards_q <= 8'd0;
            best_score_q <= 32'h8000_0000;
            best_idx_q   <= 8'hFF;
            err_q        <= 1'b0;
            acc_q        <= 32'd0;
            board_q      <= 8'd0;
            sq_q         <= 6'd0;
            code_q       <= 8'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (slave_write) begin
                        case (slave_address)
                            4'd0: state_q <= S_ACK;
                            4'd1: begin src_base_q   <= slave_writedata;      state_q <= S_LOAD; end
                            4'd2: begin dst_base_q   <= slave_writedata;      state_q <= S_LOAD; end
                            4'd3: begin num_boards_q <= slave_writedata[7:0]; state_q <= S_LOAD; end
                            default: ;
                        endcase
                    end
                end
                S_LOAD: state_q <= S_IDLE;
                S_ACK: begin
                    board_q      <= 8'd0;
                    sq_q         <= 6'd0;
                    acc_q        <= 32'd0;
                    err_q        <= 1'b0;
                    best_score_q <= 32'h8000_0000;
                    best_idx_q   <= 8'hFF;
                    state_q      <= S_CHECK;
                end
                S_CHECK: state_q <= (board_q == num_boards_q) ? S_DONE : S_RD_SQ;
                S_RD_SQ: begin
                    if (master_readdatavalid) begin
                        code_q  <= master_readdata[7:0];
                        state_q <= S_ACC;
                    end
                end
                S_ACC: begin
                    acc_q <= acc_d;
                    if (bad_code)
                        err_q <= 1'b1;
                    if (sq_q == 6'd63) begin
                        state_q <= S_WR_SCORE;
                    end else begin
                        sq_q    <= sq_q + 6'd1;
                        state_q <= S_RD_SQ;
                    end
                end
                S_WR_SCORE: begin
                    if (!master_waitrequest) begin
                        // Strict compare: on ties the earlier board keeps the best slot.
                        if ($signed(acc_q) > $signed(best_score_q)) begin
                            best_score_q <= acc_q;
                            best_idx_q   <= board_q;
                        end
                        state_q <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    board_q <= board_q + 8'd1;
                    sq_q    <= 6'd0;
                    acc_q   <= 32'd0;
                    state_q <= S_CHECK;
                end
                S_DONE: begin
                    if (slave_read && slave_address == 4'd0)
                        state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_board_eval.sv
// Directed bench for board_eval: SDRAM model answers reads from a byte-per-square board image
// and logs accepted score writes; CPU side drives the Avalon slave through blocking tasks.
module tb_board_eval;
    localparam logic [31:0] SRC   = 32'h0000_0100;
    localparam logic [31:0] DST   = 32'h0000_0200;
    localparam int          LIMIT = 3000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        slave_waitrequest;
    logic [3:0]  slave_address = 4'd0;
    logic        slave_read = 1'b0;
    logic [31:0] slave_readdata;
    logic        slave_write = 1'b0;
    logic [31:0] slave_writedata = 32'd0;
    logic        master_waitrequest = 1'b0;
    logic [31:0] master_address;
    logic        master_read;
    logic [31:0] master_readdata = 32'd0;
    logic        master_readdatavalid = 1'b0;
    logic        master_write;
    logic [31:0] master_writedata;

    board_eval dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .slave_waitrequest    (slave_waitrequest),
        .slave_address        (slave_address),
        .slave_read           (slave_read),
        .slave_readdata       (slave_readdata),
        .slave_write          (slave_write),
        .slave_writedata      (slave_writedata),
        .master_waitrequest   (master_waitrequest),
        .master_address       (master_address),
        .master_read          (master_read),
        .master_readdata      (master_readdata),
        .master_readdatavalid (master_readdatavalid),
        .master_write         (master_write),
        .master_writedata     (master_writedata)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [7:0]  mem [0:255];
    int          rd_cnt = 0;
    int          viol = 0;
    logic        rand_wait = 1'b0;
    logic        held = 1'b0;
    logic [31:0] held_a = 32'd0;
    logic [31:0] held_d = 32'd0;
    logic [31:0] wr_a [$];
    logic [31:0] wr_d [$];

    // SDRAM model, driven on the falling edge so the DUT sees stable inputs at the rising edge.
    always @(negedge clk) begin
        logic [31:0] idx;
        if (master_readdatavalid) begin
            master_readdatavalid = 1'b0;
        end else if (master_read) begin
            rd_cnt++;
            idx = master_address - SRC;
            master_readdata = (idx < 32'd256) ? {24'hA5A5A5, mem[idx[7:0]]} : 32'd0;
            master_readdatavalid = 1'b1;
        end
        master_waitrequest = rand_wait ? ($urandom_range(0, 1) == 1) : 1'b0;
        if (held && master_write && (master_address !== held_a || master_writedata !== held_d))
            viol++;
        if (master_write && !master_waitrequest) begin
            wr_a.push_back(master_address);
            wr_d.push_back(master_writedata);
        end
        held   = master_write && master_waitrequest;
        held_a = master_address;
        held_d = master_writedata;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_slave();
        int n = 0;
        #1;
        while (slave_waitrequest && n < LIMIT) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("slave_wait_bound", 32'(n < LIMIT), 32'd1);
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        slave_address   = a;
        slave_writedata = d;
        slave_write     = 1'b1;
        wait_slave();
        @(posedge clk);
        #1;
        slave_write = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        slave_address = a;
        slave_read    = 1'b1;
        wait_slave();
        d = slave_readdata;
        @(posedge clk);
        #1;
        slave_read = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'd0;
    endtask

    // Start a run of nb boards and poll status until the done bit appears.
    task automatic run(input logic [7:0] nb, output logic [31:0] st);
        logic [31:0] d;
        int n;
        wr_a.delete();
        wr_d.delete();
        rd_cnt = 0;
        bus_write(4'd3, {24'd0, nb});
        bus_write(4'd0, 32'd1);
        d = 32'd0;
        n = 0;
        while (d[0] !== 1'b1 && n < 8) begin
            bus_read(4'd0, d);
            n++;
        end
        st = d;
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] st;
        logic [7:0]  back [0:7];
        int n;
        int c;
        back[0] = 8'd4; back[1] = 8'd2; back[2] = 8'd3; back[3] = 8'd5;
        back[4] = 8'd6; back[5] = 8'd3; back[6] = 8'd2; back[7] = 8'd4;
        clear_mem();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;

        chk("rst_mread", {31'd0, master_read}, 32'd0);
        chk("rst_mwrite", {31'd0, master_write}, 32'd0);
        chk("rst_maddr", master_address, 32'hFFFF_FFFF);
        chk("rst_mwdata", master_writedata, 32'hFFFF_FFFF);
        bus_read(4'd0, d); chk("rst_status", d, 32'd0);
        bus_read(4'd1, d); chk("rst_src", d, 32'hFFFF_FFFF);
        bus_read(4'd2, d); chk("rst_dst", d, 32'hFFFF_FFFF);
        bus_read(4'd3, d); chk("rst_num", d, 32'd0);
        bus_read(4'd4, d); chk("rst_best", d, 32'h8000_0000);
        bus_read(4'd5, d); chk("rst_idx", d, 32'h0000_00FF);

        bus_write(4'd1, SRC);
        bus_write(4'd2, DST);
        bus_read(4'd1, d); chk("cfg_src", d, SRC);
        bus_read(4'd2, d); chk("cfg_dst", d, DST);

        // empty board
        run(8'd1, st);
        chk("empty_status", st, 32'd1);
        chk("empty_nwr", 32'(wr_a.size()), 32'd1);
        chk("empty_nrd", 32'(rd_cnt), 32'd64);
        if (wr_a.size() > 0) begin
            chk("empty_addr", wr_a[0], DST);
            chk("empty_data", wr_d[0], 32'd0);
        end
        bus_read(4'd4, d); chk("empty_best", d, 32'd0);
        bus_read(4'd5, d); chk("empty_idx", d, 32'd0);

        // standard start position
        for (int i = 0; i < 8; i++) begin
            mem[i]      = back[i];
            mem[8 + i]  = 8'd1;
            mem[48 + i] = 8'hFF;
            mem[56 + i] = 8'd0 - back[i];
        end
        run(8'd1, st);
        chk("start_status", st, 32'd1);
        chk("start_nwr", 32'(wr_a.size()), 32'd1);
        if (wr_d.size() > 0) chk("start_data", wr_d[0], 32'd0);

        // white queen sq27 vs black rook sq0
        clear_mem();
        mem[27] = 8'd5;
        mem[0]  = 8'hFC;
        run(8'd1, st);
        chk("qr_status", st, 32'd1);
        if (wr_d.size() > 0) chk("qr_data", wr_d[0], 32'h0000_0190);

        // lone black queen: negative score still beats the reset best value
        clear_mem();
        mem[40] = 8'hFB;
        run(8'd1, st);
        if (wr_d.size() > 0) chk("bq_data", wr_d[0], 32'hFFFF_FC7C);
        bus_read(4'd4, d); chk("bq_best", d, 32'hFFFF_FC7C);
        bus_read(4'd5, d); chk("bq_idx", d, 32'd0);

        // three boards: 100, 900, 900 -> tie keeps board 1
        clear_mem();
        mem[8]   = 8'd1;
        mem[67]  = 8'd5;
        mem[187] = 8'd5;
        run(8'd3, st);
        chk("n3_status", st, 32'd1);
        chk("n3_nwr", 32'(wr_a.size()), 32'd3);
        if (wr_a.size() == 3) begin
            chk("n3_addr0", wr_a[0], DST);
            chk("n3_addr1", wr_a[1], DST + 32'd1);
            chk("n3_addr2", wr_a[2], DST + 32'd2);
            chk("n3_data0", wr_d[0], 32'd100);
            chk("n3_data1", wr_d[1], 32'd900);
            chk("n3_data2", wr_d[2], 32'd900);
        end
        bus_read(4'd4, d); chk("n3_best", d, 32'd900);
        bus_read(4'd5, d); chk("n3_idx", d, 32'd1);

        // invalid code 7 with a stalling write port
        clear_mem();
        mem[10] = 8'd7;
        rand_wait = 1'b1;
        viol = 0;
        run(8'd1, st);
        chk("c7_status", st, 32'd3);
        if (wr_d.size() > 0) chk("c7_data", wr_d[0], 32'd0);
        chk("c7_stable", 32'(viol), 32'd0);
        rand_wait = 1'b0;
        bus_read(4'd0, d); chk("c7_idle_status", d, 32'd2);

        // -128 is invalid too; the knight still counts
        clear_mem();
        mem[5]  = 8'h80;
        mem[63] = 8'd2;
        run(8'd1, st);
        chk("m128_status", st, 32'd3);
        if (wr_d.size() > 0) chk("m128_data", wr_d[0], 32'h0000_0140);

        // N=0: no traffic, error flag cleared by the new start
        run(8'd0, st);
        chk("n0_status", st, 32'd1);
        chk("n0_nrd", 32'(rd_cnt), 32'd0);
        chk("n0_nwr", 32'(wr_a.size()), 32'd0);
        bus_read(4'd5, d); chk("n0_idx", d, 32'h0000_00FF);
        bus_read(4'd4, d); chk("n0_best", d, 32'h8000_0000);

        // reset in the middle of a square read
        bus_write(4'd3, 32'd1);
        bus_write(4'd0, 32'd1);
        n = 0;
        while (master_read !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("mid_read_seen", {31'd0, master_read}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_mread", {31'd0, master_read}, 32'd0);
        chk("mid_rst_maddr", master_address, 32'hFFFF_FFFF);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wr_a.delete();
        wr_d.delete();
        @(negedge clk);
        c = rd_cnt;
        repeat (150) @(negedge clk);
        chk("mid_no_reads", 32'(rd_cnt), 32'(c));
        chk("mid_no_writes", 32'(wr_a.size()), 32'd0);
        bus_read(4'd1, d); chk("mid_src_reset", d, 32'hFFFF_FFFF);
        bus_read(4'd0, d); chk("mid_status", d, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
